// File: rtl/serial_shift_unit.sv
// Iterative barrel-shifter replacement: moves the operand at most STEP bits per
// cycle through a single work register. It trades latency for area.
module serial_shift_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [4:0]      shamt,
  input  logic [1:0]      shift_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] SEL_SRL  = 2'b00;
  localparam logic [1:0] SEL_SLL  = 2'b01;
  localparam logic [1:0] SEL_SRA  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam logic [4:0] STEP_W = 5'(STEP);

  logic [1:0]      state;
  logic [XLEN-1:0] work;
  logic [4:0]      cnt;
  logic [1:0]      sel;

  logic [4:0]      d;
  logic [4:0]      cnt_nxt;
  logic [XLEN-1:0] shifted;

  // The final step may be shorter than STEP when shamt is not a multiple of it.
  always_comb begin
    d       = (cnt < STEP_W) ? cnt : STEP_W;
    cnt_nxt = cnt - d;
    case (sel)
      SEL_SRL: shifted = work >> d;
      SEL_SLL: shifted = work << d;
      SEL_SRA: shifted = XLEN'($signed(work) >>> d);
      default: shifted = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      work  <= '0;
      cnt   <= '0;
      sel   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sel <= shift_sel;
            cnt <= shamt;
            if (shift_sel == SEL_ZERO) begin
              work  <= '0;
              state <= S_DONE;
            end else begin
              work  <= A;
              state <= (shamt == 5'd0) ? S_DONE : S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          work <= shifted;
          cnt  <= cnt_nxt;
          if (cnt_nxt == 5'd0) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from registered state only.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out       = work;

endmodule
